// File: rtl/pktout_port_arb.sv
// pktout_port_arb: packet-atomic 2:1 arbiter in front of one egress port FIFO.
// Requester 0 (TSN stream) has strict priority over requester 1 (best-effort
// forward stream). A grant is only issued while the downstream FIFO has room
// for a max-size packet, and it is then held until the packet ends or the
// watchdog aborts it. Words from the granted requester reach the output with
// one registered cycle of latency.
// Optional feature macro: PKTOUT_ARB_STARVE_GUARD_EN -- after STARVE_MAX
// consecutive requester-0 grants taken while requester 1 waits, requester 1
// is served once. Without the macro, arbitration is pure strict priority.
// Note: rst_n is a synchronous, ACTIVE-HIGH reset despite its name.
module pktout_port_arb #(
`ifdef PKTOUT_ARB_STARVE_GUARD_EN
  parameter int STARVE_MAX = 8,
`endif
  parameter int DATA_W     = 134,
  parameter int USEDW_TH   = 200,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_req0,
  output logic              out_grant0,
  input  logic [DATA_W-1:0] in_data0,
  input  logic              in_data_wr0,
  input  logic              in_valid0,
  input  logic              in_valid_wr0,
  input  logic              in_req1,
  output logic              out_grant1,
  input  logic [DATA_W-1:0] in_data1,
  input  logic              in_data_wr1,
  input  logic              in_valid1,
  input  logic              in_valid_wr1,
  input  logic [7:0]        out_usedw,
  output logic [DATA_W-1:0] out_data,
  output logic              out_data_wr,
  output logic              out_valid,
  output logic              out_valid_wr,
  output logic [31:0]       out_pkt_cnt0,
  output logic [31:0]       out_pkt_cnt1,
  output logic [15:0]       out_abort_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TIMEOUT);
  localparam logic [7:0] USEDW_LIM = 8'(USEDW_TH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;

  logic               w_room;
  logic               w_pick1;
  logic               w_go0;
  logic               w_go1;
  logic               w_sel1;
  logic [DATA_W-1:0]  w_data;
  logic               w_data_wr;
  logic               w_valid;
  logic               w_valid_wr;
  logic               w_timeout;

  // FIFO level only matters for the IDLE decision; an active packet is never cut.
  assign w_room = (out_usedw < USEDW_LIM);

`ifdef PKTOUT_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CONSEC_END = CW'(STARVE_MAX);
  logic [CW-1:0] r_consec;

  assign w_pick1 = in_req1 && (!in_req0 || (r_consec == CONSEC_END));
`else
  assign w_pick1 = in_req1 && !in_req0;
`endif

  assign w_go1 = (r_state == S_IDLE) && w_room && w_pick1;
  assign w_go0 = (r_state == S_IDLE) && w_room && in_req0 && !w_pick1;

  // Source mux: only the granted requester is looked at; the other is ignored.
  assign w_sel1     = (r_state == S_GNT1);
  assign w_data     = w_sel1 ? in_data1     : in_data0;
  assign w_data_wr  = w_sel1 ? in_data_wr1  : in_data_wr0;
  assign w_valid    = w_sel1 ? in_valid1    : in_valid0;
  assign w_valid_wr = w_sel1 ? in_valid_wr1 : in_valid_wr0;
  assign w_timeout  = (r_timer == TMR_END);

`ifdef PKTOUT_ARB_STARVE_GUARD_EN
  // Count requester-0 grants taken while requester 1 is waiting.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_consec <= '0;
    end else if (!in_req1 || w_go1) begin
      r_consec <= '0;
    end else if (w_go0) begin
      r_consec <= r_consec + 1'b1;
    end
  end
`endif

  // Arbitration FSM, watchdog, registered output stage and packet counters.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      out_grant0    <= 1'b0;
      out_grant1    <= 1'b0;
      out_data      <= '0;
      out_data_wr   <= 1'b0;
      out_valid     <= 1'b0;
      out_valid_wr  <= 1'b0;
      out_pkt_cnt0  <= '0;
      out_pkt_cnt1  <= '0;
      out_abort_cnt <= '0;
    end else begin
      out_data_wr  <= 1'b0;
      out_valid_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (w_go1) begin
            r_state    <= S_GNT1;
            out_grant1 <= 1'b1;
          end else if (w_go0) begin
            r_state    <= S_GNT0;
            out_grant0 <= 1'b1;
          end
        end
        S_GNT0, S_GNT1: begin
          // ---- output stage: one-cycle registered forward of the granted source
          out_data_wr <= w_data_wr;
          if (w_data_wr) begin
            out_data <= w_data;
          end
          r_timer <= r_timer + 1'b1;
          if (w_valid_wr || w_timeout) begin
            // A tail arriving on the timeout cycle wins: normal completion.
            out_valid_wr <= 1'b1;
            out_valid    <= w_valid_wr ? w_valid : 1'b0;
            if (!w_valid_wr) begin
              out_abort_cnt <= out_abort_cnt + 1'b1;
            end
            if (w_sel1) begin
              out_pkt_cnt1 <= out_pkt_cnt1 + 1'b1;
            end else begin
              out_pkt_cnt0 <= out_pkt_cnt0 + 1'b1;
            end
            r_state    <= S_IDLE;
            out_grant0 <= 1'b0;
            out_grant1 <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          out_grant0 <= 1'b0;
          out_grant1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pktout_port_arb.sv
// Directed testbench for pktout_port_arb: reset, single packet, priority,
// FIFO-level gating, watchdog abort, reset mid-packet and starvation behaviour.
module tb_pktout_port_arb;

  logic         clk;
  logic         rst_n;
  logic         in_req0, in_req1;
  logic         out_grant0, out_grant1;
  logic [133:0] in_data0, in_data1;
  logic         in_data_wr0, in_data_wr1;
  logic         in_valid0, in_valid1;
  logic         in_valid_wr0, in_valid_wr1;
  logic [7:0]   out_usedw;
  logic [133:0] out_data;
  logic         out_data_wr, out_valid, out_valid_wr;
  logic [31:0]  out_pkt_cnt0, out_pkt_cnt1;
  logic [15:0]  out_abort_cnt;

  int npass = 0;
  int ntot  = 0;
  logic [31:0] exp_c0 = 0;
  logic [31:0] exp_c1 = 0;
  logic [15:0] exp_ab = 0;

  pktout_port_arb dut (
    .clk(clk), .rst_n(rst_n),
    .in_req0(in_req0), .out_grant0(out_grant0), .in_data0(in_data0),
    .in_data_wr0(in_data_wr0), .in_valid0(in_valid0), .in_valid_wr0(in_valid_wr0),
    .in_req1(in_req1), .out_grant1(out_grant1), .in_data1(in_data1),
    .in_data_wr1(in_data_wr1), .in_valid1(in_valid1), .in_valid_wr1(in_valid_wr1),
    .out_usedw(out_usedw), .out_data(out_data), .out_data_wr(out_data_wr),
    .out_valid(out_valid), .out_valid_wr(out_valid_wr),
    .out_pkt_cnt0(out_pkt_cnt0), .out_pkt_cnt1(out_pkt_cnt1),
    .out_abort_cnt(out_abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [133:0] mkw(input int i, input int n, input logic [31:0] seed);
    logic [1:0] h;
    h = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
    return {h, 100'd0, seed + 32'(i)};
  endfunction

  task automatic drv(input int r, input logic dwr, input logic [133:0] d,
                     input logic v, input logic vwr);
    if (r == 0) begin
      in_data_wr0 = dwr; in_data0 = d; in_valid0 = v; in_valid_wr0 = vwr;
    end else begin
      in_data_wr1 = dwr; in_data1 = d; in_valid1 = v; in_valid_wr1 = vwr;
    end
  endtask

  task automatic clr();
    in_data_wr0 = 0; in_valid_wr0 = 0; in_valid0 = 0;
    in_data_wr1 = 0; in_valid_wr1 = 0; in_valid1 = 0;
  endtask

  task automatic test_reset();
    rst_n = 1; in_req0 = 1; in_req1 = 1; out_usedw = 0;
    drv(0, 1, mkw(0, 1, 32'h55), 1, 1);
    drv(1, 1, mkw(0, 1, 32'h66), 1, 1);
    repeat (3) tick();
    ntot++;
    if ({out_grant0, out_grant1, out_data_wr, out_valid, out_valid_wr} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000",
               {out_grant0, out_grant1, out_data_wr, out_valid, out_valid_wr});
    else npass++;
    ntot++;
    if (out_data !== 134'd0 || out_pkt_cnt0 !== 0 || out_pkt_cnt1 !== 0 || out_abort_cnt !== 0)
      $display("FAIL reset_data: data %0h c0 %0d c1 %0d ab %0d want all 0",
               out_data, out_pkt_cnt0, out_pkt_cnt1, out_abort_cnt);
    else npass++;
    in_req0 = 0; in_req1 = 0; clr();
    rst_n = 0;
    repeat (3) tick();
    ntot++;
    if (out_grant0 !== 0 || out_grant1 !== 0)
      $display("FAIL idle_no_grant: g0 %b g1 %b want 0 0", out_grant0, out_grant1);
    else npass++;
  endtask

  task automatic test_single();
    logic [133:0] w;
    out_usedw = 0; in_req0 = 1;
    tick();
    ntot++;
    if (out_grant0 !== 1 || out_data_wr !== 0)
      $display("FAIL single_grant: g0 %b dwr %b want 1 0", out_grant0, out_data_wr);
    else npass++;
    in_req0 = 0;
    for (int i = 0; i < 4; i++) begin
      w = mkw(i, 4, 32'h100);
      drv(0, 1, w, 1, (i == 3));
      tick();
      ntot++;
      if (out_data_wr !== 1 || out_data !== w || out_valid_wr !== (i == 3))
        $display("FAIL single_word%0d: dwr %b data %0h vwr %b want 1 %0h %b",
                 i, out_data_wr, out_data, out_valid_wr, w, (i == 3));
      else npass++;
    end
    exp_c0++;
    ntot++;
    if (out_valid !== 1 || out_grant0 !== 0 || out_pkt_cnt0 !== exp_c0)
      $display("FAIL single_end: valid %b g0 %b cnt0 %0d want 1 0 %0d",
               out_valid, out_grant0, out_pkt_cnt0, exp_c0);
    else npass++;
    clr();
    tick();
    ntot++;
    if (out_data_wr !== 0 || out_valid_wr !== 0)
      $display("FAIL single_quiet: dwr %b vwr %b want 0 0", out_data_wr, out_valid_wr);
    else npass++;
  endtask

  task automatic test_priority();
    logic [133:0] w;
    out_usedw = 0; in_req0 = 1; in_req1 = 1;
    tick();
    ntot++;
    if (out_grant0 !== 1 || out_grant1 !== 0)
      $display("FAIL prio_first: g0 %b g1 %b want 1 0", out_grant0, out_grant1);
    else npass++;
    in_req0 = 0;
    for (int i = 0; i < 3; i++) begin
      w = mkw(i, 3, 32'h200);
      drv(0, 1, w, 1, (i == 2));
      drv(1, 1, mkw(0, 1, 32'hBAD), 1, 1);
      tick();
      ntot++;
      if (out_data !== w || out_pkt_cnt1 !== exp_c1)
        $display("FAIL prio_req0_word%0d: data %0h cnt1 %0d want %0h %0d",
                 i, out_data, out_pkt_cnt1, w, exp_c1);
      else npass++;
    end
    exp_c0++;
    clr();
    ntot++;
    if (out_grant0 !== 0 || out_grant1 !== 0 || out_pkt_cnt0 !== exp_c0)
      $display("FAIL prio_gap: g0 %b g1 %b cnt0 %0d want 0 0 %0d",
               out_grant0, out_grant1, out_pkt_cnt0, exp_c0);
    else npass++;
    tick();
    ntot++;
    if (out_grant1 !== 1)
      $display("FAIL prio_second: g1 %b want 1", out_grant1);
    else npass++;
    in_req1 = 0;
    for (int i = 0; i < 2; i++) begin
      w = mkw(i, 2, 32'h300);
      drv(1, 1, w, 1, (i == 1));
      drv(0, 1, mkw(0, 1, 32'hBAD), 1, 1);
      tick();
      ntot++;
      if (out_data !== w)
        $display("FAIL prio_req1_word%0d: data %0h want %0h", i, out_data, w);
      else npass++;
    end
    exp_c1++;
    clr();
    ntot++;
    if (out_pkt_cnt0 !== exp_c0 || out_pkt_cnt1 !== exp_c1 || out_grant1 !== 0)
      $display("FAIL prio_counts: cnt0 %0d cnt1 %0d g1 %b want %0d %0d 0",
               out_pkt_cnt0, out_pkt_cnt1, out_grant1, exp_c0, exp_c1);
    else npass++;
    tick();
  endtask

  task automatic test_usedw();
    bit seen;
    int n;
    logic [133:0] w;
    seen = 0;
    out_usedw = 8'd200; in_req1 = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (out_grant0 || out_grant1) seen = 1;
    end
    ntot++;
    if (seen !== 0) $display("FAIL usedw_block: grant seen %b want 0", seen);
    else npass++;
    out_usedw = 8'd10;
    n = 0;
    while (out_grant1 !== 1 && n < 2) begin
      tick();
      n++;
    end
    ntot++;
    if (out_grant1 !== 1) $display("FAIL usedw_release: g1 %b after %0d cycles want 1", out_grant1, n);
    else npass++;
    in_req1 = 0;
    out_usedw = 8'd255;
    for (int i = 0; i < 2; i++) begin
      w = mkw(i, 2, 32'h400);
      drv(1, 1, w, 1, (i == 1));
      tick();
      ntot++;
      if (out_data_wr !== 1 || out_data !== w)
        $display("FAIL usedw_no_interrupt%0d: dwr %b data %0h want 1 %0h", i, out_data_wr, out_data, w);
      else npass++;
    end
    exp_c1++;
    clr();
    tick();
    out_usedw = 8'd199; in_req0 = 1;
    tick();
    ntot++;
    if (out_grant0 !== 1) $display("FAIL usedw_199: g0 %b want 1", out_grant0);
    else npass++;
    in_req0 = 0;
    drv(0, 1, mkw(0, 1, 32'h450), 1, 1);
    tick();
    exp_c0++;
    clr();
    tick();
  endtask

  task automatic test_timeout();
    int n;
    out_usedw = 0; in_req0 = 1;
    tick();
    ntot++;
    if (out_grant0 !== 1) $display("FAIL to_grant: g0 %b want 1", out_grant0);
    else npass++;
    in_req0 = 0;
    for (int i = 0; i < 2; i++) begin
      drv(0, 1, mkw(i, 4, 32'h500), 1, 0);
      tick();
    end
    clr();
    n = 2;
    while (out_valid_wr !== 1 && n < 1100) begin
      tick();
      n++;
    end
    exp_c0++; exp_ab++;
    ntot++;
    if (n !== 1024) $display("FAIL to_latency: abort after %0d cycles want 1024", n);
    else npass++;
    ntot++;
    if (out_valid !== 0 || out_abort_cnt !== exp_ab || out_grant0 !== 0 || out_pkt_cnt0 !== exp_c0)
      $display("FAIL to_abort: valid %b ab %0d g0 %b cnt0 %0d want 0 %0d 0 %0d",
               out_valid, out_abort_cnt, out_grant0, out_pkt_cnt0, exp_ab, exp_c0);
    else npass++;
    tick();
    in_req0 = 1;
    tick();
    in_req0 = 0;
    repeat (1023) tick();
    ntot++;
    if (out_grant0 !== 1 || out_valid_wr !== 0)
      $display("FAIL to_edge_hold: g0 %b vwr %b want 1 0", out_grant0, out_valid_wr);
    else npass++;
    drv(0, 1, mkw(1, 2, 32'h600), 1, 1);
    tick();
    exp_c0++;
    clr();
    ntot++;
    if (out_valid_wr !== 1 || out_valid !== 1 || out_abort_cnt !== exp_ab || out_pkt_cnt0 !== exp_c0)
      $display("FAIL to_edge_complete: vwr %b valid %b ab %0d cnt0 %0d want 1 1 %0d %0d",
               out_valid_wr, out_valid, out_abort_cnt, out_pkt_cnt0, exp_ab, exp_c0);
    else npass++;
    tick();
  endtask

  task automatic test_reset_mid();
    out_usedw = 0; in_req1 = 1;
    tick();
    in_req1 = 0;
    drv(1, 1, mkw(0, 3, 32'h700), 1, 0);
    tick();
    clr();
    rst_n = 1;
    tick();
    rst_n = 0;
    exp_c0 = 0; exp_c1 = 0; exp_ab = 0;
    ntot++;
    if (out_grant1 !== 0 || out_valid_wr !== 0 || out_pkt_cnt0 !== 0 || out_pkt_cnt1 !== 0 || out_abort_cnt !== 0)
      $display("FAIL reset_mid: g1 %b vwr %b c0 %0d c1 %0d ab %0d want 0 0 0 0 0",
               out_grant1, out_valid_wr, out_pkt_cnt0, out_pkt_cnt1, out_abort_cnt);
    else npass++;
    tick();
  endtask

  task automatic test_starve();
    int n;
    int got;
    int expg;
    out_usedw = 0; in_req0 = 1; in_req1 = 1;
    for (int p = 0; p < 18; p++) begin
      n = 0;
      while (!out_grant0 && !out_grant1 && n < 8) begin
        tick();
        n++;
      end
      got = out_grant1 ? 1 : (out_grant0 ? 0 : -1);
`ifdef PKTOUT_ARB_STARVE_GUARD_EN
      expg = (p % 9 == 8) ? 1 : 0;
`else
      expg = 0;
`endif
      ntot++;
      if (got !== expg) $display("FAIL starve_pkt%0d: granted %0d want %0d", p, got, expg);
      else npass++;
      if (got >= 0) begin
        drv(got, 1, mkw(0, 1, 32'(p)), 1, 1);
        tick();
        clr();
        if (got == 1) exp_c1++;
        else exp_c0++;
      end
    end
    in_req0 = 0; in_req1 = 0;
    tick();
    ntot++;
    if (out_pkt_cnt0 !== exp_c0 || out_pkt_cnt1 !== exp_c1)
      $display("FAIL starve_counts: cnt0 %0d cnt1 %0d want %0d %0d",
               out_pkt_cnt0, out_pkt_cnt1, exp_c0, exp_c1);
    else npass++;
  endtask

  initial begin
    rst_n = 1; in_req0 = 0; in_req1 = 0; out_usedw = 0;
    in_data0 = '0; in_data1 = '0;
    clr();
    test_reset();
    test_single();
    test_priority();
    test_usedw();
    test_timeout();
    test_reset_mid();
    test_starve();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
